// File: rtl/johnson_pkg.sv
// johnson_pkg: lock-state enum, error-count ceiling and Johnson sequence helper shared by decoder and bench
package johnson_pkg;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;
  localparam int JW = 8;
  localparam logic [7:0] ERR_MAX = 8'hff;
  function automatic logic [JW-1:0] next_johnson(input logic [JW-1:0] q);
    return {q[JW-2:0], ~q[JW-1]};
  endfunction
endpackage

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: code sample bus and decoded status
//   master drives code_in/code_valid/err_clr and reads the decoded results;
//   slave (the decoder) drives pos, pos_valid, step_up, step_dn, err_illegal, err_skip, locked, err_count
interface johnson_decoder_if #(
  parameter int W = 8,
  parameter int PW = $clog2(2*W)
);
  logic [W-1:0] code_in;
  logic code_valid;
  logic err_clr;
  logic [PW-1:0] pos;
  logic pos_valid;
  logic step_up;
  logic step_dn;
  logic err_illegal;
  logic err_skip;
  logic locked;
  logic [7:0] err_count;
  modport master (
    output code_in, code_valid, err_clr,
    input pos, pos_valid, step_up, step_dn, err_illegal, err_skip, locked, err_count
  );
  modport slave (
    input code_in, code_valid, err_clr,
    output pos, pos_valid, step_up, step_dn, err_illegal, err_skip, locked, err_count
  );
endinterface

// File: rtl/johnson_code_check.sv
// johnson_code_check: combinational legality check and position decode of a Johnson word
//   code  in  W   sampled word
//   legal out 1   word is one of the 2W Johnson states
//   pos   out PW  position 0..2W-1 (meaningful only when legal)
module johnson_code_check #(
  parameter int W = 8,
  localparam int PW = $clog2(2*W)
) (
  input  logic [W-1:0]  code,
  output logic          legal,
  output logic [PW-1:0] pos
);
  logic [W-1:0] t;
  logic [PW:0] ones;
  always_comb begin
    // folding MSB=1 words onto their complement turns both halves into a 2^n-1 test
    t = code[W-1] ? ~code : code;
    ones = '0;
    for (int i = 0; i < W; i++) ones = ones + (PW+1)'(code[i]);
    legal = (t & (t + 1'b1)) == '0;
    pos = code[W-1] ? PW'((PW+1)'(2*W) - ones) : PW'(ones);
  end
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes sampled Johnson words, tracks step direction, lock FSM and error counter
//   clk, rst  clock and synchronous active-high reset
//   bus       johnson_decoder_if slave: code_in/code_valid/err_clr in, decoded status out
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int W = 8,
  parameter int LOCK_COUNT = 4,
  localparam int PW = $clog2(2*W)
) (
  input logic clk,
  input logic rst,
  johnson_decoder_if.slave bus
);
  lock_state_t state;
  logic [3:0] lock_cnt;
  logic legal;
  logic [PW-1:0] cpos;
  logic [PW:0] d;
  logic is_up, is_dn, is_hold, err_ev;
  johnson_code_check #(.W(W)) u_chk (.code(bus.code_in), .legal(legal), .pos(cpos));
  // bus.pos doubles as the reference position; state==UNLOCKED means no valid reference
  always_comb begin
    d = cpos >= bus.pos ? {1'b0, cpos} - {1'b0, bus.pos}
                        : {1'b0, cpos} + (PW+1)'(2*W) - {1'b0, bus.pos};
    is_hold = d == '0;
    is_up = d == (PW+1)'(1);
    is_dn = d == (PW+1)'(2*W-1);
    err_ev = bus.code_valid && (!legal || (state != UNLOCKED && !is_hold && !is_up && !is_dn));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      lock_cnt <= '0;
      bus.pos <= '0;
      bus.pos_valid <= 1'b0;
      bus.step_up <= 1'b0;
      bus.step_dn <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_skip <= 1'b0;
      bus.locked <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.pos_valid <= 1'b0;
      bus.step_up <= 1'b0;
      bus.step_dn <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_skip <= 1'b0;
      if (bus.err_clr) bus.err_count <= '0;
      else if (err_ev && bus.err_count != ERR_MAX) bus.err_count <= bus.err_count + 8'd1;
      if (bus.code_valid) begin
        if (!legal) begin
          bus.err_illegal <= 1'b1;
          state <= UNLOCKED;
          bus.locked <= 1'b0;
          lock_cnt <= '0;
        end else begin
          bus.pos_valid <= 1'b1;
          bus.pos <= cpos;
          if (state == UNLOCKED) begin
            state <= ACQUIRE;
            lock_cnt <= '0;
          end else if (is_up || is_dn) begin
            bus.step_up <= is_up;
            bus.step_dn <= is_dn;
            if (state == ACQUIRE) begin
              lock_cnt <= lock_cnt + 4'd1;
              if (lock_cnt == 4'(LOCK_COUNT-1)) begin
                state <= LOCKED;
                bus.locked <= 1'b1;
              end
            end
          end else if (!is_hold) begin
            bus.err_skip <= 1'b1;
            lock_cnt <= '0;
            state <= ACQUIRE;
            bus.locked <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: randomized and directed stimulus checked against a position-table reference model
module tb_johnson_decoder;
  import johnson_pkg::*;
  localparam int LOCK = 4;
  logic clk = 1'b0;
  logic rst;
  johnson_decoder_if #(.W(8)) bus();
  johnson_decoder #(.W(8), .LOCK_COUNT(LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] tbl [16];
  int n_vec = 0;
  int n_bad = 0;
  int m_pos, m_err, m_cnt;
  bit m_ref, m_locked;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lookup(input logic [7:0] c);
    for (int k = 0; k < 16; k++) if (tbl[k] == c) return k;
    return -1;
  endfunction
  task automatic apply(input logic [7:0] c, input logic v, input logic clr, input logic r);
    int idx, dl;
    bit e_pv, e_up, e_dn, e_ill, e_skip;
    bus.code_in = c;
    bus.code_valid = v;
    bus.err_clr = clr;
    rst = r;
    @(posedge clk);
    #1;
    e_pv = 0; e_up = 0; e_dn = 0; e_ill = 0; e_skip = 0;
    if (r) begin
      m_pos = 0; m_err = 0; m_cnt = 0; m_ref = 0; m_locked = 0;
    end else begin
      if (v) begin
        idx = lookup(c);
        if (idx < 0) begin
          e_ill = 1; m_ref = 0; m_locked = 0; m_cnt = 0;
        end else begin
          e_pv = 1;
          dl = (idx - m_pos + 16) % 16;
          if (!m_ref) begin
            m_ref = 1; m_cnt = 0;
          end else if (dl == 1 || dl == 15) begin
            e_up = dl == 1; e_dn = dl == 15;
            if (!m_locked) begin
              m_cnt++;
              if (m_cnt == LOCK) m_locked = 1;
            end
          end else if (dl != 0) begin
            e_skip = 1; m_cnt = 0; m_locked = 0;
          end
          m_pos = idx;
        end
      end
      if (clr) m_err = 0;
      else if ((e_ill || e_skip) && m_err < 255) m_err++;
    end
    chk("pos", 32'(bus.pos), 32'(m_pos));
    chk("pos_valid", 32'(bus.pos_valid), 32'(e_pv));
    chk("step_up", 32'(bus.step_up), 32'(e_up));
    chk("step_dn", 32'(bus.step_dn), 32'(e_dn));
    chk("err_illegal", 32'(bus.err_illegal), 32'(e_ill));
    chk("err_skip", 32'(bus.err_skip), 32'(e_skip));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("err_count", 32'(bus.err_count), 32'(m_err));
  endtask
  task automatic go(input int k);
    apply(tbl[k % 16], 1'b1, 1'b0, 1'b0);
  endtask
  function automatic logic [7:0] rand_illegal();
    logic [7:0] c;
    c = 8'b00100100;
    for (int t = 0; t < 200; t++) begin
      c = 8'($urandom);
      if (lookup(c) < 0) return c;
    end
    return 8'b00100100;
  endfunction
  initial begin
    int r;
    tbl[0] = '0;
    for (int k = 1; k < 16; k++) tbl[k] = next_johnson(tbl[k-1]);
    m_pos = 0; m_err = 0; m_cnt = 0; m_ref = 0; m_locked = 0;
    apply(8'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    for (int k = 0; k <= 4; k++) go(k);
    chk("lock_at_pos4", 32'(bus.locked), 32'd1);
    for (int k = 5; k <= 15; k++) go(k);
    go(0);
    chk("wrap_up", 32'(bus.step_up), 32'd1);
    go(15);
    chk("wrap_dn", 32'(bus.step_dn), 32'd1);
    for (int k = 0; k <= 3; k++) go(k);
    go(6);
    chk("skip_unlock", 32'(bus.locked), 32'd0);
    chk("skip_count", 32'(bus.err_count), 32'd1);
    for (int k = 7; k <= 10; k++) go(k);
    chk("relock", 32'(bus.locked), 32'd1);
    apply(8'b00100100, 1'b1, 1'b0, 1'b0);
    chk("illegal_pos", 32'(bus.pos), 32'd10);
    go(11);
    chk("first_after_illegal", 32'(bus.step_up), 32'd0);
    for (int i = 0; i < 300; i++) apply(rand_illegal(), 1'b1, 1'b0, 1'b0);
    chk("err_saturate", 32'(bus.err_count), 32'd255);
    apply(8'b00100100, 1'b1, 1'b1, 1'b0);
    chk("clr_wins", 32'(bus.err_count), 32'd0);
    for (int k = 10; k <= 14; k++) go(k);
    apply(tbl[15], 1'b1, 1'b0, 1'b1);
    chk("rst_mid_stream", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) bus.code_in = tbl[(m_pos + 1) % 16];
      else if (r < 60) bus.code_in = tbl[(m_pos + 15) % 16];
      else if (r < 70) bus.code_in = tbl[m_pos];
      else if (r < 80) bus.code_in = tbl[(m_pos + int'($urandom_range(2, 14))) % 16];
      else if (r < 88) bus.code_in = rand_illegal();
      else bus.code_in = 8'($urandom);
      apply(bus.code_in, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 299) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
